ivl_uvm_ovl_fire_monitor: RTL and testbench

Collects the `fire` outputs of up to NUM_CHECKERS OVL checker instances in a test and turns them into time-stamped events and per-category counts. It sits directly downstream of the checkers and upstream of the bench's reporting logic.
- One FIFO entry is produced per cycle in which any fire bit is set, so simultaneous firings are never serialised or lost while FIFO space remains.
- Counters and a first-error latch let a test end with a single pass/fail query.

---
 rtl/ivl_uvm_ovl_fire_monitor_pkg.sv | 21 ++
 rtl/ivl_uvm_ovl_fire_monitor_if.sv | 24 ++
 rtl/ivl_uvm_ovl_sync_fifo.sv | 81 ++++++++
 rtl/ivl_uvm_ovl_fire_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_ivl_uvm_ovl_fire_monitor.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ivl_uvm_ovl_fire_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_mon_pkg
// Shared constants for the OVL fire monitor: the layout of one checker's
// three-bit fire field and a helper that sizes checker-index fields.
// No ports (package).
// ---------------------------------------------------------------------------
package ivl_uvm_ovl_mon_pkg;

  // Bit positions inside one checker's fire field
  localparam int FIRE_2STATE = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER  = 2;
  localparam int FIRE_BITS   = 3;

  // Width of a checker index; never narrower than one bit so a single
  // checker still gets a legal port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_fire_monitor_if.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_monitor_if
// Event stream from the fire monitor to the reporting logic (valid/ready).
//   evt_valid  head entry present
//   evt_ready  consumer takes the head entry
//   evt_time   timestamp of the head entry
//   evt_fire   fire snapshot of the head entry
// master = monitor side, slave = consumer side.
// ---------------------------------------------------------------------------
interface ivl_uvm_ovl_fire_monitor_if #(
  parameter int NUM_CHECKERS = 4,
  parameter int TS_WIDTH     = 32
) ();
  import ivl_uvm_ovl_mon_pkg::*;

  logic                              evt_valid;
  logic                              evt_ready;
  logic [TS_WIDTH-1:0]               evt_time;
  logic [FIRE_BITS*NUM_CHECKERS-1:0] evt_fire;

  modport master (output evt_valid, output evt_time, output evt_fire, input evt_ready);
  modport slave  (input evt_valid, input evt_time, input evt_fire, output evt_ready);

endinterface

// File: rtl/ivl_uvm_ovl_sync_fifo.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_sync_fifo
// Synchronous shift-down FIFO whose head is always storage slot 0, so the
// head data is a plain register. Push and pop may happen in the same cycle,
// including when full (the pop frees the slot the push fills).
//   clk, reset  clock, synchronous active-high reset
//   push_i      write din_i (ignored when full unless popping)
//   din_i       entry to write
//   pop_i       remove head (ignored when empty)
//   head_o      current head entry
//   empty_o     no entries (registered)
//   full_o      DEPTH entries (registered)
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             pop_ok, push_ok;
  logic [AW-1:0]    wr_idx;

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    pop_ok  = pop_i && !empty_q;
    push_ok = push_i && (!full_q || pop_ok);
    // Slot just past the occupied region, after any shift from the pop
    wr_idx  = AW'(pop_ok ? cnt_q - CW'(1) : cnt_q);

    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    if (push_ok) mem_d[wr_idx] = din_i;

    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign head_o  = mem_q[0];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/ivl_uvm_ovl_fire_monitor.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_monitor
// Turns the fire outputs of NUM_CHECKERS OVL checkers into time-stamped
// events (one FIFO entry per cycle with any fire bit) plus saturating
// per-category counts, a first-error latch and FIFO overflow tracking.
//   clk, reset       clock, synchronous active-high reset
//   enable           gate for fire (timestamp keeps running)
//   fire             {chkN-1 .. chk0}, each {cover, xcheck, 2state}
//   clear            pulse: zero counters, first-error latch, overflow
//   evt              event stream (master modport)
//   err/xchk/cov_count  saturating popcount sums per fire category
//   first_err_*      index/time of the first 2-state failure
//   overflow, drop_count  sticky drop flag and saturating drop count
// Fire is registered on the first edge and acted on at the next one.
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_fire_monitor
  import ivl_uvm_ovl_mon_pkg::*;
#(
  parameter int NUM_CHECKERS = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [FIRE_BITS*NUM_CHECKERS-1:0]    fire,
  input  logic                                 clear,
  ivl_uvm_ovl_fire_monitor_if.master           evt,
  output logic [CNT_WIDTH-1:0]                 err_count,
  output logic [CNT_WIDTH-1:0]                 xchk_count,
  output logic [CNT_WIDTH-1:0]                 cov_count,
  output logic                                 first_err_valid,
  output logic [id_width(NUM_CHECKERS)-1:0]    first_err_id,
  output logic [TS_WIDTH-1:0]                  first_err_time,
  output logic                                 overflow,
  output logic [CNT_WIDTH-1:0]                 drop_count
);

  localparam int FW  = FIRE_BITS * NUM_CHECKERS;
  localparam int IDW = id_width(NUM_CHECKERS);
  localparam int IW  = $clog2(NUM_CHECKERS + 1);
  localparam int SW  = CNT_WIDTH + 1;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [FW-1:0]       fire;
  } evt_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [IW-1:0]        b);
    logic [SW-1:0] s;
    s = {1'b0, a} + SW'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic [TS_WIDTH-1:0] ts_q;
  logic                vld_p0;
  logic                clr_p0;
  logic [FW-1:0]       fire_p0;
  logic [TS_WIDTH-1:0] ts_p0;

  // ---- stage p0: sample fire with the current timestamp ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q   <= '0;
      vld_p0 <= 1'b0;
      clr_p0 <= 1'b0;
    end else begin
      ts_q   <= ts_q + TS_WIDTH'(1);
      vld_p0 <= enable && (fire != '0);
      clr_p0 <= clear;
    end
  end

  // Data is qualified by vld_p0 downstream, so it needs no reset
  always_ff @(posedge clk) begin
    fire_p0 <= fire;
    ts_p0   <= ts_q;
  end

  // ---- stage p1: FIFO push, counters, first-error latch ----
  logic [IW-1:0]  err_inc, xchk_inc, cov_inc;
  logic           err_hit;
  logic [IDW-1:0] err_idx;

  // Descending scan so the lowest erroring index is the last one written
  always_comb begin
    err_inc  = '0;
    xchk_inc = '0;
    cov_inc  = '0;
    err_hit  = 1'b0;
    err_idx  = '0;
    for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
      if (fire_p0[FIRE_BITS*i + FIRE_2STATE]) begin
        err_inc = err_inc + IW'(1);
        err_hit = 1'b1;
        err_idx = IDW'(i);
      end
      if (fire_p0[FIRE_BITS*i + FIRE_XCHECK]) xchk_inc = xchk_inc + IW'(1);
      if (fire_p0[FIRE_BITS*i + FIRE_COVER])  cov_inc  = cov_inc + IW'(1);
    end
  end

  evt_t push_evt, head_evt;
  logic fifo_empty, fifo_full, pop, drop;

  assign push_evt = '{ts: ts_p0, fire: fire_p0};
  assign pop      = evt.evt_valid && evt.evt_ready;
  // Full implies non-empty, so any pop request frees a slot
  assign drop     = vld_p0 && fifo_full && !pop;

  ivl_uvm_ovl_sync_fifo #(
    .WIDTH($bits(evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (vld_p0),
    .din_i  (push_evt),
    .pop_i  (pop),
    .head_o (head_evt),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_time  = head_evt.ts;
  assign evt.evt_fire  = head_evt.fire;

  logic [CNT_WIDTH-1:0] err_q, err_d, xchk_q, xchk_d, cov_q, cov_d, drop_q, drop_d;
  logic                 fe_vld_q, fe_vld_d, ovf_q, ovf_d;
  logic [IDW-1:0]       fe_id_q, fe_id_d;
  logic [TS_WIDTH-1:0]  fe_ts_q, fe_ts_d;

  // clear overrides any firing sampled alongside it
  always_comb begin
    err_d    = err_q;
    xchk_d   = xchk_q;
    cov_d    = cov_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    fe_vld_d = fe_vld_q;
    fe_id_d  = fe_id_q;
    fe_ts_d  = fe_ts_q;
    if (clr_p0) begin
      err_d    = '0;
      xchk_d   = '0;
      cov_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
      fe_vld_d = 1'b0;
      fe_id_d  = '0;
      fe_ts_d  = '0;
    end else if (vld_p0) begin
      err_d  = sat_add(err_q, err_inc);
      xchk_d = sat_add(xchk_q, xchk_inc);
      cov_d  = sat_add(cov_q, cov_inc);
      if (!fe_vld_q && err_hit) begin
        fe_vld_d = 1'b1;
        fe_id_d  = err_idx;
        fe_ts_d  = ts_p0;
      end
      if (drop) begin
        ovf_d  = 1'b1;
        drop_d = sat_add(drop_q, IW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= '0;
      xchk_q   <= '0;
      cov_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      fe_vld_q <= 1'b0;
      fe_id_q  <= '0;
      fe_ts_q  <= '0;
    end else begin
      err_q    <= err_d;
      xchk_q   <= xchk_d;
      cov_q    <= cov_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      fe_vld_q <= fe_vld_d;
      fe_id_q  <= fe_id_d;
      fe_ts_q  <= fe_ts_d;
    end
  end

  assign err_count       = err_q;
  assign xchk_count      = xchk_q;
  assign cov_count       = cov_q;
  assign drop_count      = drop_q;
  assign overflow        = ovf_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_id    = fe_id_q;
  assign first_err_time  = fe_ts_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_monitor.sv
// ---------------------------------------------------------------------------
// tb_ivl_uvm_ovl_fire_monitor
// Directed bench for the OVL fire monitor (4 checkers, 16-bit counters,
// depth-8 FIFO, 32-bit timestamp). Fire layout per checker: {cov,xchk,err}.
// ---------------------------------------------------------------------------
module tb_ivl_uvm_ovl_fire_monitor;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] fire;
  logic        clear;
  logic [15:0] err_count, xchk_count, cov_count, drop_count;
  logic        first_err_valid;
  logic [1:0]  first_err_id;
  logic [31:0] first_err_time;
  logic        overflow;

  ivl_uvm_ovl_fire_monitor_if #(.NUM_CHECKERS(4), .TS_WIDTH(32)) evt_if ();

  ivl_uvm_ovl_fire_monitor #(
    .NUM_CHECKERS(4),
    .CNT_WIDTH   (16),
    .FIFO_DEPTH  (8),
    .TS_WIDTH    (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fire           (fire),
    .clear          (clear),
    .evt            (evt_if),
    .err_count      (err_count),
    .xchk_count     (xchk_count),
    .cov_count      (cov_count),
    .first_err_valid(first_err_valid),
    .first_err_id   (first_err_id),
    .first_err_time (first_err_time),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned tnow   = 0;   // value of the DUT timestamp in the current cycle
  int unsigned t_mark;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    tnow++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tnow  = 0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    fire   = '0;
    clear  = 1'b0;
    evt_if.evt_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_time", evt_if.evt_time, 0);
    check("rst_fire", evt_if.evt_fire, 0);
    check("rst_err", err_count, 0);
    check("rst_xchk", xchk_count, 0);
    check("rst_cov", cov_count, 0);
    check("rst_fev", first_err_valid, 0);
    check("rst_fid", first_err_id, 0);
    check("rst_fts", first_err_time, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);

    // 20 idle cycles, then an X-check firing stamped 20
    repeat (20) step();
    check("idle_valid", evt_if.evt_valid, 0);
    check("idle_err", err_count, 0);
    fire = 12'h002;
    step();
    fire = '0;
    check("lat_valid_early", evt_if.evt_valid, 0);
    check("lat_xchk_early", xchk_count, 0);
    step();
    check("ts20_valid", evt_if.evt_valid, 1);
    check("ts20_time", evt_if.evt_time, 20);
    check("ts20_fire", evt_if.evt_fire, 12'h002);
    check("ts20_xchk", xchk_count, 1);

    // Reset with an entry pending, then chk2 err + chk0 cover at ts 7
    do_reset();
    check("rst2_valid", evt_if.evt_valid, 0);
    check("rst2_xchk", xchk_count, 0);
    repeat (7) step();
    fire = 12'h044;
    step();
    fire = '0;
    step();
    check("t7_valid", evt_if.evt_valid, 1);
    check("t7_time", evt_if.evt_time, 7);
    check("t7_fire", evt_if.evt_fire, 12'h044);
    check("t7_err", err_count, 1);
    check("t7_cov", cov_count, 1);
    check("t7_xchk", xchk_count, 0);
    check("t7_fev", first_err_valid, 1);
    check("t7_fid", first_err_id, 2);
    check("t7_fts", first_err_time, 7);
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    check("t7_popped", evt_if.evt_valid, 0);

    // Later error on chk0 leaves the latch alone
    fire = 12'h001;
    step();
    fire = '0;
    step();
    check("later_err", err_count, 2);
    check("later_fid", first_err_id, 2);
    check("later_fts", first_err_time, 7);
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    check("later_popped", evt_if.evt_valid, 0);

    // 10 consecutive cover firings with ready low: 8 held, 2 dropped
    t_mark = tnow;
    fire = 12'h004;
    repeat (10) step();
    fire = '0;
    step();
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 2);
    check("ovf_cov", cov_count, 11);
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", evt_if.evt_valid, 1);
      check("drain_time", evt_if.evt_time, t_mark + k);
      check("drain_fire", evt_if.evt_fire, 12'h004);
      step();
    end
    evt_if.evt_ready = 1'b0;
    check("drain_empty", evt_if.evt_valid, 0);

    // Full FIFO with push and pop on the same edge: accepted, no drop
    t_mark = tnow;
    fire = 12'h002;
    repeat (9) step();
    fire = '0;
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    check("fullpp_drop", drop_count, 2);
    check("fullpp_ovf", overflow, 1);
    check("fullpp_xchk", xchk_count, 9);
    evt_if.evt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("fullpp_valid", evt_if.evt_valid, 1);
      check("fullpp_time", evt_if.evt_time, t_mark + k);
      step();
    end
    evt_if.evt_ready = 1'b0;
    check("fullpp_empty", evt_if.evt_valid, 0);

    // enable low: no event, counts unchanged
    enable = 1'b0;
    fire = 12'h007;
    step();
    step();
    fire = '0;
    enable = 1'b1;
    step();
    check("dis_valid", evt_if.evt_valid, 0);
    check("dis_err", err_count, 2);
    check("dis_xchk", xchk_count, 9);
    check("dis_cov", cov_count, 11);

    // clear coincident with a chk3 error: cleared, event still pushed
    fire = 12'h200;
    clear = 1'b1;
    step();
    fire = '0;
    clear = 1'b0;
    step();
    check("clr_err", err_count, 0);
    check("clr_cov", cov_count, 0);
    check("clr_fev", first_err_valid, 0);
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_count, 0);
    check("clr_valid", evt_if.evt_valid, 1);
    check("clr_fire", evt_if.evt_fire, 12'h200);
    // Latch re-arms after clear: chk1 error
    t_mark = tnow;
    fire = 12'h008;
    step();
    fire = '0;
    step();
    check("rearm_fev", first_err_valid, 1);
    check("rearm_fid", first_err_id, 1);
    check("rearm_fts", first_err_time, t_mark);
    check("rearm_err", err_count, 1);

    // Saturation: 21844 cycles x3 + 2 = 0xFFFE, then +3 saturates
    do_reset();
    fire = 12'h049;
    repeat (21844) step();
    fire = 12'h009;
    step();
    fire = '0;
    step();
    check("sat_pre", err_count, 16'hFFFE);
    check("sat_fid", first_err_id, 0);
    check("sat_fts", first_err_time, 0);
    fire = 12'h049;
    step();
    fire = '0;
    step();
    check("sat_hit", err_count, 16'hFFFF);
    fire = 12'h049;
    step();
    fire = '0;
    step();
    check("sat_hold", err_count, 16'hFFFF);
    check("sat_drop", drop_count, 21839);
    check("sat_ovf", overflow, 1);

    // Reset mid-drain, with fire asserted during the reset cycle
    evt_if.evt_ready = 1'b1;
    step();
    fire = 12'h049;
    do_reset();
    fire = '0;
    evt_if.evt_ready = 1'b0;
    check("mid_rst_valid", evt_if.evt_valid, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_fev", first_err_valid, 0);
    step();
    check("rst_in_ignored_valid", evt_if.evt_valid, 0);
    check("rst_in_ignored_err", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
